// File: rtl/core_pipe_ctrl.sv
// Decode-stage progress controller: owns the s2 valid bit, interlocks load-use
// hazards against one outstanding load, handles flush and fetch-byte consumption.
module core_pipe_ctrl #(
  parameter int REG_ADDR_R = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  s1_valid,
  input  logic                  s1_16bit,
  input  logic                  s1_32bit,
  input  logic [REG_ADDR_R:0]   s1_rs1_addr,
  input  logic [REG_ADDR_R:0]   s1_rs2_addr,
  input  logic                  s1_rs1_used,
  input  logic                  s1_rs2_used,
  input  logic [REG_ADDR_R:0]   s1_rd,
  input  logic                  s1_is_load,
  output logic                  s2_eat_2,
  output logic                  s2_eat_4,
  output logic                  s2_ld,
  output logic                  s2_valid,
  output logic                  s3_valid,
  input  logic                  s3_ready,
  input  logic                  flush,
  input  logic                  ld_done,
  input  logic                  ld_cancel,
  output logic                  ev_hazard,
  output logic                  ev_backpr,
  output logic [CNT_W-1:0]      cnt_hazard,
  output logic [CNT_W-1:0]      cnt_backpr
);

  logic                s2_valid_q, s2_valid_d;
  logic                s2_is_load_q, s2_is_load_d;
  logic [REG_ADDR_R:0] s2_rd_q, s2_rd_d;
  logic                pend_vld_q, pend_vld_d;
  logic [REG_ADDR_R:0] pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]    cnt_hazard_q, cnt_hazard_d;
  logic [CNT_W-1:0]    cnt_backpr_q, cnt_backpr_d;

  logic ld_blk, s2_fire, s2_free, hazard, s1_fire;
  logic rs1_match, rs2_match;

  // x0 is hardwired zero, so it can never be the target of a pending load
  function automatic logic src_match(
    input logic [REG_ADDR_R:0] a,
    input logic                used,
    input logic                s2v,
    input logic                s2l,
    input logic [REG_ADDR_R:0] s2rd,
    input logic                pv,
    input logic                dn,
    input logic [REG_ADDR_R:0] prd
  );
    return used && (a != '0) &&
           ((s2v && s2l && (a == s2rd)) || (pv && !dn && (a == prd)));
  endfunction

  always_comb begin
    ld_blk    = s2_is_load_q & pend_vld_q & ~ld_done;
    s3_valid  = s2_valid_q & ~ld_blk;
    s2_fire   = s3_valid & s3_ready;
    s2_free   = ~s2_valid_q | s2_fire;
    rs1_match = src_match(s1_rs1_addr, s1_rs1_used, s2_valid_q, s2_is_load_q,
                          s2_rd_q, pend_vld_q, ld_done, pend_rd_q);
    rs2_match = src_match(s1_rs2_addr, s1_rs2_used, s2_valid_q, s2_is_load_q,
                          s2_rd_q, pend_vld_q, ld_done, pend_rd_q);
    hazard    = s1_valid & (rs1_match | rs2_match);
    // Gated by reset so nothing is consumed while reset is held
    s1_fire   = g_resetn & s1_valid & s2_free & ~hazard & ~flush;
    s2_ld     = s1_fire;
    s2_eat_2  = s1_fire & s1_16bit;
    s2_eat_4  = s1_fire & s1_32bit;
    ev_hazard = hazard & s2_free & ~flush;
    ev_backpr = s2_valid_q & ~s3_ready & ~flush;
  end

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_is_load_d = s2_is_load_q;
    s2_rd_d      = s2_rd_q;
    pend_vld_d   = pend_vld_q;
    pend_rd_d    = pend_rd_q;
    cnt_hazard_d = cnt_hazard_q;
    cnt_backpr_d = cnt_backpr_q;

    if (flush)        s2_valid_d = 1'b0;
    else if (s1_fire) s2_valid_d = 1'b1;
    else if (s2_fire) s2_valid_d = 1'b0;

    if (s1_fire) begin
      s2_is_load_d = s1_is_load;
      s2_rd_d      = s1_rd;
    end

    // A new issue beats a same-cycle done: the done belongs to the older load
    if (s2_fire && s2_is_load_q && !flush) begin
      pend_vld_d = 1'b1;
      pend_rd_d  = s2_rd_q;
    end else if (ld_done || ld_cancel) begin
      pend_vld_d = 1'b0;
    end

    if (ev_hazard) cnt_hazard_d = cnt_hazard_q + CNT_W'(1);
    if (ev_backpr) cnt_backpr_d = cnt_backpr_q + CNT_W'(1);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      s2_valid_q   <= 1'b0;
      s2_is_load_q <= 1'b0;
      s2_rd_q      <= '0;
      pend_vld_q   <= 1'b0;
      pend_rd_q    <= '0;
      cnt_hazard_q <= '0;
      cnt_backpr_q <= '0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_is_load_q <= s2_is_load_d;
      s2_rd_q      <= s2_rd_d;
      pend_vld_q   <= pend_vld_d;
      pend_rd_q    <= pend_rd_d;
      cnt_hazard_q <= cnt_hazard_d;
      cnt_backpr_q <= cnt_backpr_d;
    end
  end

  assign s2_valid   = s2_valid_q;
  assign cnt_hazard = cnt_hazard_q;
  assign cnt_backpr = cnt_backpr_q;

endmodule

// File: doc/core_pipe_ctrl.md
# core_pipe_ctrl

Pipeline progress controller for the fetch-to-decode-to-execute boundary. It owns the decode output register valid bit and generates its load enable. It interlocks load-use hazards against one outstanding load, kills the decode slot on flush, and tells the fetch buffer how many bytes were consumed. It sits beside the decode/operand-gather stage and gates its register updates and its handshake with execute.

## Interface
Parameters:
- REG_ADDR_R, 4, MSB index of register address.
- CNT_W, 32, width of performance event counters.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  global reset; asynchronous, active-low.
- s1_valid  in  1  fetch buffer presents a decodable instruction.
- s1_16bit / s1_32bit  in  1  instruction size (one-hot when s1_valid).
- s1_rs1_addr / s1_rs2_addr  in  REG_ADDR_R+1  source registers of the s1 instruction.
- s1_rs1_used / s1_rs2_used  in  1  the source operand is actually read.
- s1_rd  in  REG_ADDR_R+1  destination of the s1 instruction.
- s1_is_load  in  1  s1 instruction is a load.
- s2_eat_2 / s2_eat_4  out  1  fetch buffer consumes 2/4 bytes this cycle.
- s2_ld  out  1  load enable for decode operand/rd registers.
- s2_valid  out  1  decode register holds a live instruction.
- s3_valid  out  1  decode offers its instruction to execute.
- s3_ready  in  1  execute accepts this cycle.
- flush  in  1  kill decode slot (branch taken / trap).
- ld_done  in  1  outstanding load data available for forwarding this cycle.
- ld_cancel  in  1  outstanding load aborted (bus error / trap).
- ev_hazard  out  1  cycle lost to a load-use interlock.
- ev_backpr  out  1  cycle s2 held by !s3_ready.
- cnt_hazard / cnt_backpr  out  CNT_W  event counters.

## Operation
- Internal state: s2_valid; s2_is_load; s2_rd; pend_vld and pend_rd (one outstanding load beyond s2); two counters.
- ld_blk = s2_is_load & pend_vld & !ld_done. A second load is not issued while the first is outstanding.
- s3_valid = s2_valid & !ld_blk.
- s2_fire = s3_valid & s3_ready.
- s2_free = !s2_valid | s2_fire.
- match(a, used) = used & (a != 0) & ((s2_valid & s2_is_load & a == s2_rd) | (pend_vld & !ld_done & a == pend_rd)).
- hazard = s1_valid & (match(rs1, rs1_used) | match(rs2, rs2_used)).
- s1_fire = s1_valid & s2_free & !hazard & !flush.
- s2_ld = s1_fire.
- s2_eat_2 = s1_fire & s1_16bit.
- s2_eat_4 = s1_fire & s1_32bit.
- s2_valid next: 0 if flush; else 1 if s1_fire; else 0 if s2_fire; else hold.
- s2_is_load and s2_rd load on s1_fire.
- pend_vld next, in priority order:
  - set if s2_fire & s2_is_load & !flush; pend_rd <= s2_rd.
  - else clear if ld_done or ld_cancel.
  - else hold.
  - Set wins over a simultaneous done, because done refers to the older load.
- flush does not clear pend_vld; the outstanding load is older than the flushing instruction.
- ev_hazard = hazard & s2_free & !flush.
- ev_backpr = s2_valid & !s3_ready & !flush.
- Each counter increments by 1 on its event and wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous assert, synchronous release) sets to 0: s2_valid, s2_is_load, s2_rd, pend_vld, pend_rd, cnt_hazard, cnt_backpr. With s2_valid=0, every output is 0.
- s1 to s2 takes 1 cycle: an instruction accepted (s1_fire) in cycle N gives s2_valid=1 in N+1.
- Full throughput: with s3_ready held high, one instruction per cycle.
- Load-use: a load fires to s3 in cycle N; a dependent instruction in s1 stalls until the ld_done cycle M and fires in M itself. Penalty is M-N cycles. With ld_done in N+1, the penalty is 1 cycle.
- flush in cycle N: s1_fire=0 and s2_eat_*=0 in N; s2_valid=0 in N+1.
- flush with s3_ready high in the same cycle: s2 is not counted as issued and does not set pend_vld.
- rd/rs equal to x0 never matches.
- Reset mid-stall drops all state immediately; no bytes are eaten.

## Test plan
- Back-to-back ALU ops, s3_ready=1, alternating 16/32-bit: s2_eat_2/s2_eat_4 alternate every cycle, s2_valid stays 1, cnt_hazard stays 0.
- Load x5 followed by add x6,x5,x7, ld_done 3 cycles after the load issues: add stalls 3 cycles, s2_eat_4 asserts in the ld_done cycle, cnt_hazard=3.
- Load x0 followed by a reader of x0: no stall.
- Load x5 with rs1_used=0 and a match only on an unused field: no stall.
- s3_ready low for 4 cycles with s2 full and s1 valid: s2_ld=0, no eat, cnt_backpr=4, s2 contents held.
- flush together with s1_valid and s2_valid: no eat, s2_valid=0 next cycle. An outstanding pend_vld survives, then clears on ld_cancel.
- Two loads back-to-back, second issued while the first is pending: s3_valid stays 0 for the second until ld_done. In the ld_done cycle the second issues and pend_rd takes the second's rd.
- Assert g_resetn=0 mid-hazard: all outputs 0 asynchronously; counters reset to 0.
